// File: rtl/controlador_temporizador_if.sv
// Keypad/door/tick inputs and display/magnetron outputs of the microwave cook timer.
// The master side (keypad and control panel) drives the requests; the slave side (the timer) drives the display.
interface controlador_temporizador_if;
  logic [3:0] keypad;
  logic       key_valid;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_closed;
  logic       tick;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;
  logic       mag_on;
  logic       done;

  modport master (
    output keypad, key_valid, start, stop, clear, door_closed, tick,
    input  min, sec_tens, sec_units, mag_on, done
  );

  modport slave (
    input  keypad, key_valid, start, stop, clear, door_closed, tick,
    output min, sec_tens, sec_units, mag_on, done
  );
endinterface

// File: rtl/controlador_temporizador.sv
// Microwave cook-timer sequencer: BCD keypad entry, start/pause/clear, door interlock,
// and a 1 Hz countdown that drives the magnetron enable and the done flag.
module controlador_temporizador (
  input logic                        clk,
  input logic                        clearn,
  controlador_temporizador_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] min_r;
  logic [3:0] tens_r;
  logic [3:0] units_r;
  logic [3:0] min_next_s;
  logic [3:0] tens_next_s;
  logic [3:0] units_next_s;
  logic [11:0] dec_s;
  logic       mag_on_r;
  logic       done_r;
  logic       time_zero_s;
  logic       key_ok_s;

  // One-second BCD borrow chain: units mod 10, tens mod 6, then minutes.
  function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                          input logic [3:0] u);
    logic [3:0] m_n;
    logic [3:0] t_n;
    logic [3:0] u_n;
    m_n = m;
    t_n = t;
    u_n = u;
    if (u == 4'd0) begin
      u_n = 4'd9;
      if (t == 4'd0) begin
        t_n = 4'd5;
        m_n = m - 4'd1;
      end else begin
        t_n = t - 4'd1;
      end
    end else begin
      u_n = u - 4'd1;
    end
    return {m_n, t_n, u_n};
  endfunction

  assign time_zero_s = (min_r == 4'd0) && (tens_r == 4'd0) && (units_r == 4'd0);
  // A key is refused when the shift would push units above 5 into the seconds-tens digit.
  assign key_ok_s    = bus.key_valid && (bus.keypad <= 4'd9) && (units_r <= 4'd5);

  // Next-state and next-digit decode, resolved in the fixed request priority order.
  always_comb begin
    state_next_s = state_r;
    min_next_s   = min_r;
    tens_next_s  = tens_r;
    units_next_s = units_r;
    dec_s        = bcd_dec(min_r, tens_r, units_r);
    if (bus.clear) begin
      state_next_s = IDLE;
      min_next_s   = 4'd0;
      tens_next_s  = 4'd0;
      units_next_s = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && bus.door_closed && !time_zero_s) begin
            state_next_s = RUN;
          end else if (key_ok_s) begin
            min_next_s   = tens_r;
            tens_next_s  = units_r;
            units_next_s = bus.keypad;
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN: begin
          if (bus.stop || !bus.door_closed) begin
            state_next_s = PAUSE;
          end else if (time_zero_s) begin
            state_next_s = DONE;
          end else if (bus.tick) begin
            min_next_s   = dec_s[11:8];
            tens_next_s  = dec_s[7:4];
            units_next_s = dec_s[3:0];
            if (dec_s == 12'h000) begin
              state_next_s = DONE;
            end else begin
              state_next_s = RUN;
            end
          end else begin
            state_next_s = RUN;
          end
        end
        PAUSE: begin
          if (!bus.stop && bus.door_closed && bus.start) begin
            state_next_s = RUN;
          end else begin
            state_next_s = PAUSE;
          end
        end
        DONE: begin
          if (bus.start) begin
            state_next_s = IDLE;
            min_next_s   = 4'd0;
            tens_next_s  = 4'd0;
            units_next_s = 4'd0;
          end else begin
            state_next_s = DONE;
          end
        end
        default: begin
          state_next_s = IDLE;
          min_next_s   = 4'd0;
          tens_next_s  = 4'd0;
          units_next_s = 4'd0;
        end
      endcase
    end
  end

  // State, digit and output registers; flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_r  <= IDLE;
      min_r    <= 4'd0;
      tens_r   <= 4'd0;
      units_r  <= 4'd0;
      mag_on_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      min_r    <= min_next_s;
      tens_r   <= tens_next_s;
      units_r  <= units_next_s;
      mag_on_r <= (state_next_s == RUN);
      done_r   <= (state_next_s == DONE);
    end
  end

  assign bus.min       = min_r;
  assign bus.sec_tens  = tens_r;
  assign bus.sec_units = units_r;
  assign bus.mag_on    = mag_on_r;
  assign bus.done      = done_r;

endmodule
